// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, encoder class codes, loader state enum
// and the per-format bit packing helpers used by the instruction encoder.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] CLS_R       = 3'd0;
  localparam logic [2:0] CLS_I_ALU   = 3'd1;
  localparam logic [2:0] CLS_LOAD    = 3'd2;
  localparam logic [2:0] CLS_STORE   = 3'd3;
  localparam logic [2:0] CLS_BRANCH  = 3'd4;
  localparam logic [2:0] CLS_LUI     = 3'd5;
  localparam logic [2:0] CLS_JAL     = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  // imm holds byte-offset bits [12:1]; bit 0 never reaches the word.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:12] imm, input logic [4:0] rd);
    return {imm, rd, OP_LUI};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

endpackage

// File: rtl/instr_format.sv
// Combinational RV32I packer: instruction class plus fields in, 32-bit word
// and an illegal-class flag out.
module instr_format
  import rv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R:      word = enc_r(funct7, rs2, rs1, funct3, rd, OP_R);
      CLS_I_ALU:  word = enc_i(imm[11:0], rs1, funct3, rd, OP_IMM);
      CLS_LOAD:   word = enc_i(imm[11:0], rs1, funct3, rd, OP_LOAD);
      CLS_STORE:  word = enc_s(imm[11:0], rs2, rs1, funct3);
      CLS_BRANCH: word = enc_b(imm[12:1], rs2, rs1, funct3);
      CLS_LUI:    word = enc_u(imm[31:12], rd);
      CLS_JAL:    word = enc_j(imm[20:1], rd);
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I program loader: accepts field beats, encodes them and writes the words
// to consecutive instruction-memory addresses through a registered write port.
//
// state   | meaning
// IDLE    | no session; beats refused
// LOAD    | session open; beats accepted while count < DEPTH
// DONE    | session closed by finish; held until start or rst
module instr_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                error_q, error_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;

  instr_format u_format (
    .cls     (in_class),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // start wins over finish and drops any beat offered in the same cycle
    accept      = in_valid && in_ready && !start;

    if (start) begin
      state_d = ST_LOAD;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              error_d = 1'b1;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = count_q[ADDR_W-1:0];
              mem_wdata_d = enc_word;
              count_d     = count_q + ONE_C;
            end
          end
          if (finish) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      error_q     <= error_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign error     = error_q;
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of encoded vectors plus short
// hand-written sequences for session control, overflow and reset.
module tb_instr_encoder;

  logic        clk, rst, start, finish, in_valid;
  logic [2:0]  in_class, in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, busy, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_error;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .done(done), .error(error)
  );

  instr_encoder #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .count(s_count), .busy(s_busy), .done(s_done), .error(s_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  vec_t bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input vec_t v);
    in_valid  = 1'b1;
    in_class  = v.cls;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
  endtask

  initial begin
    //         cls   f3    f7     rd  rs1 rs2 imm           expected word
    vecs[0] = '{3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093};
    vecs[1] = '{3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3};
    vecs[2] = '{3'd3, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423};
    vecs[3] = '{3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3};
    vecs[4] = '{3'd5, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7};
    vecs[5] = '{3'd6, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF};
    vecs[6] = '{3'd2, 3'd2, 7'h00, 5'd4, 5'd2, 5'd0, 32'd12,       32'h00C12203};
    vecs[7] = '{3'd0, 3'd0, 7'h20, 5'd6, 5'd7, 5'd8, 32'd0,        32'h40838333};
    bad     = '{3'd7, 3'd1, 7'h7F, 5'd9, 5'd9, 5'd9, 32'hFFFFFFFF, 32'h0};

    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_class = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(); tick();
    chk("reset in_ready", in_ready, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset count", count, 0);
    chk("reset busy/done/error", {busy, done, error}, 0);
    rst = 1'b0;
    tick();
    chk("idle in_ready", in_ready, 0);

    // back-to-back table vectors
    start = 1'b1; tick(); start = 1'b0;
    chk("load busy", busy, 1);
    chk("load in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      set_beat(vecs[i]);
      tick();
      chk($sformatf("vec%0d mem_we", i), mem_we, 1);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, i);
      chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].exp);
      chk($sformatf("vec%0d count", i), count, i + 1);
    end
    in_valid = 1'b0;
    tick();
    chk("strobe single pulse", mem_we, 0);
    chk("count after stream", count, 8);

    // illegal class between two legal beats
    start = 1'b1; tick(); start = 1'b0;
    chk("restart count", count, 0);
    set_beat(vecs[0]); tick();
    chk("err pre write", mem_we, 1);
    set_beat(bad); tick();
    chk("illegal no write", mem_we, 0);
    chk("illegal error", error, 1);
    chk("illegal count", count, 1);
    set_beat(vecs[5]); tick();
    chk("post illegal addr", mem_addr, 1);
    chk("post illegal wdata", mem_wdata, vecs[5].exp);
    chk("error sticky", error, 1);
    in_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("start clears error", error, 0);
    chk("start clears count", count, 0);

    // beat together with finish
    set_beat(vecs[1]); finish = 1'b1; tick();
    finish = 1'b0; in_valid = 1'b0;
    chk("finish beat we", mem_we, 1);
    chk("finish beat addr", mem_addr, 0);
    chk("finish beat wdata", mem_wdata, vecs[1].exp);
    chk("finish done", {done, busy}, 2'b10);
    chk("done in_ready", in_ready, 0);
    set_beat(vecs[2]); tick(); in_valid = 1'b0;
    chk("done ignores beat", mem_we, 0);
    chk("done held", done, 1);

    // start together with a beat in LOAD drops the beat
    start = 1'b1; tick();
    set_beat(vecs[2]); tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start+beat no write", mem_we, 0);
    chk("start+beat count", count, 0);
    chk("start+beat busy", busy, 1);

    // ADDR_W=2 instance fills up at four words
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(vecs[i]);
      chk($sformatf("small in_ready %0d", i), s_in_ready, (i < 4) ? 1 : 0);
      tick();
      if (i < 4) begin
        chk($sformatf("small we %0d", i), s_mem_we, 1);
        chk($sformatf("small addr %0d", i), s_mem_addr, i);
        chk($sformatf("small wdata %0d", i), s_mem_wdata, vecs[i].exp);
      end else begin
        chk("small full no write", s_mem_we, 0);
        chk("small full count", s_count, 4);
        chk("small full busy", s_busy, 1);
      end
    end
    in_valid = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    chk("small done", s_done, 1);

    // reset right after an acceptance cancels the pending strobe
    start = 1'b1; tick(); start = 1'b0;
    set_beat(vecs[4]); tick(); in_valid = 1'b0;
    chk("pre-reset we", mem_we, 1);
    rst = 1'b1; tick();
    chk("rst cancels we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst count", count, 0);
    chk("rst flags", {busy, done, error, in_ready}, 0);
    rst = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
